// File: rtl/p20_game_ctrl_if.sv
// Game sequencer I/O bundle: frame timing, button and collision in;
// speed, halt, reset, jump, score and state out.
interface p20_game_ctrl_if;
  logic        frame_tick;
  logic        btn;
  logic        collide;
  logic [23:0] speed;
  logic        halt;
  logic        game_rst;
  logic        jump;
  logic [15:0] score_bcd;
  logic [1:0]  state;

  // Controller side
  modport master (
    input  frame_tick, btn, collide,
    output speed, halt, game_rst, jump, score_bcd, state
  );

  // Environment side (stimulus / consumers)
  modport slave (
    output frame_tick, btn, collide,
    input  speed, halt, game_rst, jump, score_bcd, state
  );
endinterface

// File: rtl/p20_game_ctrl.sv
// Dino game sequencer: ATTRACT/START/RUN/DEAD FSM, button debounce,
// speed schedule and saturating 4-digit BCD score. All outputs registered.
module p20_game_ctrl #(
  parameter logic [23:0] SPEED_INIT   = 24'd200000,
  parameter logic [23:0] SPEED_MIN    = 24'd80000,
  parameter logic [23:0] SPEED_STEP   = 24'd8000,
  parameter int          LEVEL_FRAMES = 600,
  parameter int          DEBOUNCE     = 4,
  parameter int          DEAD_HOLD    = 60
) (
  input  logic           clk,
  input  logic           sys_rst_n,
  p20_game_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ATTRACT = 2'b00,
    START   = 2'b01,
    RUN     = 2'b10,
    DEAD    = 2'b11
  } state_t;

  localparam int LW = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
  localparam int DW = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;
  localparam int BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [LW-1:0] LVL_MAX  = LW'(LEVEL_FRAMES - 1);
  localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_HOLD);
  localparam logic [BW-1:0] DB_MAX   = BW'(DEBOUNCE - 1);
  // Step-down threshold computed one bit wider so MIN+STEP cannot overflow
  localparam logic [24:0]   STEP_THR = {1'b0, SPEED_MIN} + {1'b0, SPEED_STEP};

  state_t          state_q, state_d;
  logic            btn_s1, btn_s2;
  logic            btn_db, btn_db_q;
  logic [BW-1:0]   db_cnt;
  logic            btn_press;
  logic [23:0]     speed_q;
  logic [15:0]     score_q;
  logic [LW-1:0]   level_ctr;
  logic [DW-1:0]   dead_ctr;
  logic            halt_q, game_rst_q, jump_q;
  logic            run_tick;

  // BCD +1 with ripple carry; holds at 9999
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        c;
    r = s;
    c = (s != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= bus.btn;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: flip btn_db after DEBOUNCE consecutive disagreeing frame samples
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (bus.frame_tick) begin
        if (btn_s2 != btn_db) begin
          if (db_cnt == DB_MAX) begin
            btn_db <= btn_s2;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  // Rising edge only: a button held through death never re-triggers
  assign btn_press = btn_db & ~btn_db_q;

  // Collision outranks the frame tick in the same cycle
  assign run_tick = (state_q == RUN) && !bus.collide && bus.frame_tick;

  // FSM state register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ATTRACT;
    else            state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ATTRACT: if (btn_press) state_d = START;
      START:   state_d = RUN;
      RUN:     if (bus.collide) state_d = DEAD;
      DEAD:    if (btn_press && dead_ctr == DEAD_MAX) state_d = START;
      default: state_d = ATTRACT;
    endcase
  end

  // Game datapath and registered control outputs, driven from next state
  // so halt/game_rst/jump change on the same edge as the state
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      speed_q    <= SPEED_INIT;
      score_q    <= '0;
      level_ctr  <= '0;
      dead_ctr   <= '0;
      halt_q     <= 1'b1;
      game_rst_q <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      game_rst_q <= (state_d == START);
      halt_q     <= (state_d != RUN);
      jump_q     <= (state_d == RUN) && btn_db;
      if (state_d == START) begin
        speed_q   <= SPEED_INIT;
        score_q   <= '0;
        level_ctr <= '0;
        dead_ctr  <= '0;
      end else if (run_tick) begin
        score_q <= bcd_inc(score_q);
        if (level_ctr == LVL_MAX) begin
          level_ctr <= '0;
          if ({1'b0, speed_q} >= STEP_THR) speed_q <= speed_q - SPEED_STEP;
          else                             speed_q <= SPEED_MIN;
        end else begin
          level_ctr <= level_ctr + LW'(1);
        end
      end else if (state_q == DEAD && bus.frame_tick && dead_ctr != DEAD_MAX) begin
        dead_ctr <= dead_ctr + DW'(1);
      end
    end
  end

  assign bus.speed     = speed_q;
  assign bus.halt      = halt_q;
  assign bus.game_rst  = game_rst_q;
  assign bus.jump      = jump_q;
  assign bus.score_bcd = score_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_p20_game_ctrl.sv
// Scoreboard bench for p20_game_ctrl with small parameters.
module tb_p20_game_ctrl;

  logic clk;
  logic sys_rst_n;
  p20_game_ctrl_if bus();

  p20_game_ctrl #(
    .SPEED_INIT  (24'd100),
    .SPEED_MIN   (24'd50),
    .SPEED_STEP  (24'd30),
    .LEVEL_FRAMES(4),
    .DEBOUNCE    (2),
    .DEAD_HOLD   (3)
  ) dut (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_err = 0;
  int   tick_per = 10, tick_cnt = 0, ticks_left = 0;
  int   starts = 0, grst_cnt = 0, seq_bad = 0;
  logic [1:0] last_st = 2'b00;

  localparam int S_ST = 0, S_SPD = 1, S_HALT = 2, S_GRST = 3, S_JUMP = 4,
                 S_SCORE = 5, S_STARTS = 6, S_GRSTN = 7, S_SEQBAD = 8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_ST:     return 32'(bus.state);
      S_SPD:    return 32'(bus.speed);
      S_HALT:   return 32'(bus.halt);
      S_GRST:   return 32'(bus.game_rst);
      S_JUMP:   return 32'(bus.jump);
      S_SCORE:  return 32'(bus.score_bcd);
      S_STARTS: return 32'(starts);
      S_GRSTN:  return 32'(grst_cnt);
      S_SEQBAD: return 32'(seq_bad);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  // One clock edge plus a monitor of game_rst / state sequencing
  task automatic edge_1();
    @(posedge clk);
    #1;
    if (bus.game_rst) grst_cnt++;
    if (bus.game_rst && bus.state != 2'b01) seq_bad++;
    if (bus.state == 2'b01 && last_st != 2'b01) starts++;
    if (bus.state == 2'b10 && last_st != 2'b10 && last_st != 2'b01) seq_bad++;
    last_st = bus.state;
  endtask

  // Edge, then schedule frame_tick from the tick budget
  task automatic step();
    edge_1();
    if (ticks_left > 0 && tick_cnt == 0) begin
      bus.frame_tick = 1'b1;
      ticks_left--;
    end else begin
      bus.frame_tick = 1'b0;
    end
    tick_cnt = (tick_cnt + 1) % tick_per;
  endtask

  task automatic run_ticks(input int n);
    ticks_left = n;
    tick_cnt   = 0;
    while (ticks_left > 0) step();
    repeat (3) step();
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int max);
    int n;
    n = 0;
    while (bus.state != s && n < max) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.state), 32'(s));
  endtask

  task automatic settle_btn(input logic v);
    bus.btn = v;
    repeat (3) step();
  endtask

  int s0, g0;

  initial begin
    sys_rst_n      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.btn        = 1'b0;
    bus.collide    = 1'b0;
    repeat (3) edge_1();

    // Reset values
    push("rst_state", S_ST, 0);     push("rst_speed", S_SPD, 100);
    push("rst_halt", S_HALT, 1);    push("rst_grst", S_GRST, 0);
    push("rst_jump", S_JUMP, 0);    push("rst_score", S_SCORE, 0);
    sb_check();
    sys_rst_n = 1'b1;
    repeat (2) step();

    // 1. press from ATTRACT -> START (one cycle) -> RUN
    settle_btn(1'b1);
    ticks_left = 2; tick_cnt = 0;
    wait_state("t1_to_start", 2'b01, 200);
    push("t1_start_grst", S_GRST, 1); push("t1_start_halt", S_HALT, 1);
    push("t1_start_speed", S_SPD, 100); push("t1_start_score", S_SCORE, 0);
    sb_check();
    step();
    push("t1_run_state", S_ST, 2);   push("t1_run_grst", S_GRST, 0);
    push("t1_run_halt", S_HALT, 0);  push("t1_run_jump", S_JUMP, 1);
    sb_check();
    repeat (5) step();
    push("t1_starts", S_STARTS, 1);  push("t1_grst_cycles", S_GRSTN, 1);
    sb_check();

    // 2. twelve ticks in RUN, speed schedule with floor clamp
    bus.btn = 1'b0;
    run_ticks(4);
    push("t2_score4", S_SCORE, 32'h0004); push("t2_speed4", S_SPD, 70);
    push("t2_jump_rel", S_JUMP, 0);
    sb_check();
    run_ticks(4);
    push("t2_score8", S_SCORE, 32'h0008); push("t2_speed8", S_SPD, 50);
    sb_check();
    run_ticks(4);
    push("t2_score12", S_SCORE, 32'h0012); push("t2_speed12", S_SPD, 50);
    push("t2_halt", S_HALT, 0);
    sb_check();

    // 4. collide coincident with frame_tick
    bus.frame_tick = 1'b1;
    bus.collide    = 1'b1;
    edge_1();
    bus.frame_tick = 1'b0;
    bus.collide    = 1'b0;
    push("t4_state", S_ST, 3);       push("t4_halt", S_HALT, 1);
    push("t4_score", S_SCORE, 32'h0012); push("t4_jump", S_JUMP, 0);
    sb_check();

    // 5. early press ignored, held press ignored, fresh press restarts
    s0 = starts;
    settle_btn(1'b1);
    run_ticks(2);
    repeat (3) step();
    push("t5_early_state", S_ST, 3); push("t5_early_starts", S_STARTS, s0);
    sb_check();
    run_ticks(3);
    repeat (3) step();
    push("t5_held_state", S_ST, 3);  push("t5_held_starts", S_STARTS, s0);
    push("t5_dead_score", S_SCORE, 32'h0012);
    sb_check();
    settle_btn(1'b0);
    run_ticks(2);
    settle_btn(1'b1);
    ticks_left = 2; tick_cnt = 0;
    wait_state("t5_restart", 2'b01, 200);
    push("t5_score0", S_SCORE, 0);   push("t5_speed", S_SPD, 100);
    push("t5_grst", S_GRST, 1);
    sb_check();
    step();
    push("t5_run", S_ST, 2);         push("t5_run_halt", S_HALT, 0);
    sb_check();

    // 3. BCD carry and saturation with a tick every clock
    bus.btn  = 1'b0;
    tick_per = 1;
    run_ticks(99);
    push("t3_0099", S_SCORE, 32'h0099);
    sb_check();
    run_ticks(1);
    push("t3_0100", S_SCORE, 32'h0100);
    sb_check();
    run_ticks(9898);
    push("t3_9998", S_SCORE, 32'h9998);
    sb_check();
    run_ticks(1);
    push("t3_9999", S_SCORE, 32'h9999);
    sb_check();
    run_ticks(2);
    push("t3_sat", S_SCORE, 32'h9999); push("t3_speed_floor", S_SPD, 50);
    push("t3_state", S_ST, 2);
    sb_check();

    // 6. asynchronous reset mid-RUN, then glitchy button
    tick_per = 10;
    g0 = grst_cnt;
    s0 = starts;
    edge_1();
    #2 sys_rst_n = 1'b0;
    #1;
    push("t6_state", S_ST, 0);       push("t6_speed", S_SPD, 100);
    push("t6_halt", S_HALT, 1);      push("t6_score", S_SCORE, 0);
    push("t6_jump", S_JUMP, 0);      push("t6_grst", S_GRST, 0);
    sb_check();
    @(posedge clk);
    #1 sys_rst_n = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      settle_btn(1'b1);
      run_ticks(1);
      settle_btn(1'b0);
      run_ticks(1);
    end
    push("t6_glitch_state", S_ST, 0); push("t6_glitch_starts", S_STARTS, s0);
    push("t6_no_grst", S_GRSTN, g0);  push("t6_seq_ok", S_SEQBAD, 0);
    sb_check();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
